// File: rtl/tt_um_rte_envelope_pdm_if.sv
`timescale 1ns/1ps
// tt_um_rte_envelope_pdm_if
//   Signal bundle between the sine synthesizer/keyboard side and the
//   envelope + PDM block.
//   master: drives sample_in, gate, retrig; observes the envelope outputs.
//   slave : the envelope block itself.
//   sample_in  [7:0] synthesizer sample, offset-binary, 128 = silence
//   gate             high while a note key is held
//   retrig           one-cycle pulse, restart envelope from 0
//   env_level  [7:0] current envelope amplitude
//   sample_out [7:0] enveloped sample, offset-binary
//   pdm_out          first-order delta-sigma bitstream
//   busy             envelope not idle
interface tt_um_rte_envelope_pdm_if;
  logic [7:0] sample_in;
  logic       gate;
  logic       retrig;
  logic [7:0] env_level;
  logic [7:0] sample_out;
  logic       pdm_out;
  logic       busy;

  modport master (
    output sample_in, gate, retrig,
    input  env_level, sample_out, pdm_out, busy
  );

  modport slave (
    input  sample_in, gate, retrig,
    output env_level, sample_out, pdm_out, busy
  );
endinterface

// File: rtl/tt_um_rte_envelope_pdm.sv
`timescale 1ns/1ps
// tt_um_rte_envelope_pdm
//   Attack/sustain/release amplitude envelope applied to an 8-bit
//   offset-binary audio sample, followed by a first-order delta-sigma
//   modulator so a single pin plus an RC filter can carry the audio.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of tt_um_rte_envelope_pdm_if (sample_in, gate,
//            retrig in; env_level, sample_out, pdm_out, busy out)
//   Parameters:
//     ATTACK_DIV   clocks per +1 envelope step while attacking (>=2)
//     RELEASE_DIV  clocks per -1 envelope step while releasing (>=2)
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | silent, env held at 0, waiting for gate
//   ST_ATTACK  | env ramps up one step per ATTACK_DIV clocks
//   ST_SUSTAIN | env held at 255 while gate stays high
//   ST_RELEASE | env ramps down one step per RELEASE_DIV clocks
module tt_um_rte_envelope_pdm #(
  parameter int ATTACK_DIV  = 512,
  parameter int RELEASE_DIV = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  tt_um_rte_envelope_pdm_if.slave        bus
);

  localparam int DIV_MAX = (ATTACK_DIV > RELEASE_DIV) ? ATTACK_DIV : RELEASE_DIV;
  localparam int PW      = $clog2(DIV_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      env_level, env_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic            busy_q;
  logic [7:0]      sample_out_q;
  logic [7:0]      pdm_acc;
  logic            pdm_q;

  logic            tick_attack;
  logic            tick_release;

  assign tick_attack  = (presc == PW'(ATTACK_DIV - 1));
  assign tick_release = (presc == PW'(RELEASE_DIV - 1));

  // ---------------------------------------------------------------------
  // Envelope FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      env_level <= 8'd0;
      presc     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      env_level <= env_nxt;
      presc     <= presc_nxt;
      busy_q    <= (state_nxt != ST_IDLE);
    end
  end

  // presc_nxt defaults to 0, so every state change and every tick clears
  // the prescaler; only the "still counting" branches advance it.
  always_comb begin
    state_nxt = state;
    env_nxt   = env_level;
    presc_nxt = '0;

    if (bus.retrig && bus.gate) begin
      state_nxt = ST_ATTACK;
      env_nxt   = 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          env_nxt = 8'd0;
          if (bus.gate) state_nxt = ST_ATTACK;
        end

        ST_ATTACK: begin
          if (!bus.gate) begin
            state_nxt = ST_RELEASE;
          end else if (env_level == 8'hFF) begin
            // resumed from a release that had not yet left full scale
            state_nxt = ST_SUSTAIN;
          end else if (tick_attack) begin
            env_nxt = env_level + 8'd1;
            if (env_level == 8'hFE) state_nxt = ST_SUSTAIN;
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end

        ST_SUSTAIN: begin
          env_nxt = 8'hFF;
          if (!bus.gate) state_nxt = ST_RELEASE;
        end

        ST_RELEASE: begin
          if (bus.gate) begin
            state_nxt = ST_ATTACK;
          end else if (env_level == 8'd0) begin
            // gate dropped while an attack was still at zero
            state_nxt = ST_IDLE;
          end else if (tick_release) begin
            env_nxt = env_level - 8'd1;
            if (env_level == 8'd1) state_nxt = ST_IDLE;
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end

        default: begin
          state_nxt = ST_IDLE;
          env_nxt   = 8'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Amplitude scaling: centre the sample, multiply by env, floor-divide by
  // 256 and re-bias. |s*env| <= 32640 so a 16-bit signed product is exact;
  // prod[15:8] is the arithmetic >>>8, and adding 128 to that 8-bit signed
  // value is just an MSB flip.
  // ---------------------------------------------------------------------
  logic signed [8:0]  s_centered;
  logic signed [15:0] prod;
  logic [7:0]         sample_nxt;
  logic               unused_prod_lsbs;

  assign s_centered       = $signed({1'b0, bus.sample_in}) - 9'sd128;
  assign prod             = 16'(s_centered) * $signed(16'({1'b0, env_level}));
  assign sample_nxt       = {~prod[15], prod[14:8]};
  assign unused_prod_lsbs = ^prod[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out_q <= 8'd128;
    end else begin
      sample_out_q <= sample_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // First-order delta-sigma: carry out of the 8-bit accumulator is the bit.
  // ---------------------------------------------------------------------
  logic [8:0] pdm_sum;

  assign pdm_sum = {1'b0, pdm_acc} + {1'b0, sample_out_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdm_acc <= 8'd0;
      pdm_q   <= 1'b0;
    end else begin
      pdm_acc <= pdm_sum[7:0];
      pdm_q   <= pdm_sum[8];
    end
  end

  assign bus.env_level  = env_level;
  assign bus.sample_out = sample_out_q;
  assign bus.pdm_out    = pdm_q;
  assign bus.busy       = busy_q;

endmodule
